// File: rtl/async_fifo.sv
// -----------------------------------------------------------------------------
// async_fifo
//   Dual-clock FIFO carrying DATA_SIZE-bit words from the wclk domain to the
//   rclk domain. Pointers are ADDR_SIZE+1 bits (extra wrap bit), exchanged
//   between domains in Gray code through 2-flop synchronizers. Reads are
//   first-word fall-through: rData always shows the head word.
//
// Ports
//   wclk, wrst       write clock, asynchronous active-low write reset
//   rclk, rrst       read clock, asynchronous active-low read reset
//   wData, winc      write data and write request (ignored while wFull)
//   rinc             pop request (ignored while rEmpty)
//   rData            head-of-FIFO data (combinational from memory)
//   wFull            FIFO full, wclk domain
//   wHalf_full       write-side occupancy >= DEPTH/2, wclk domain
//   rEmpty           FIFO empty, rclk domain
//   rHalf_empty      read-side occupancy <= DEPTH/2, rclk domain
// -----------------------------------------------------------------------------
module async_fifo #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 4
) (
   input  logic                 wclk,
   input  logic                 wrst,
   input  logic                 rclk,
   input  logic                 rrst,
   input  logic [DATA_SIZE-1:0] wData,
   input  logic                 winc,
   input  logic                 rinc,
   output logic [DATA_SIZE-1:0] rData,
   output logic                 wFull,
   output logic                 wHalf_full,
   output logic                 rEmpty,
   output logic                 rHalf_empty
);

   localparam int DEPTH = 1 << ADDR_SIZE;
   localparam logic [ADDR_SIZE:0] HALF = (ADDR_SIZE + 1)'(DEPTH / 2);

   logic [DATA_SIZE-1:0] mem [DEPTH];

   // write domain state
   logic [ADDR_SIZE:0] wbin, wptr, wq1_rptr, wq2_rptr;
   logic [ADDR_SIZE:0] wbin_next, wgray_next, wq2_rbin, wocc;
   logic               full_val, half_full_val;

   // read domain state
   logic [ADDR_SIZE:0] rbin, rptr, rq1_wptr, rq2_wptr;
   logic [ADDR_SIZE:0] rbin_next, rgray_next, rq2_wbin, rocc;
   logic               empty_val, half_empty_val;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
      logic [ADDR_SIZE:0] b;
      b = g;
      for (int unsigned i = 1; i <= ADDR_SIZE; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

   // ---------------------------------------------------------------- write side
   always_ff @(posedge wclk) begin
      if (winc && !wFull) begin
         mem[wbin[ADDR_SIZE-1:0]] <= wData;
      end
   end

   always_comb begin
      wbin_next     = wbin + (ADDR_SIZE + 1)'(winc && !wFull);
      wgray_next    = wbin_next ^ (wbin_next >> 1);
      wq2_rbin      = gray2bin(wq2_rptr);
      wocc          = wbin_next - wq2_rbin;
      // full when the write pointer is one lap ahead: top two Gray bits inverted
      full_val      = (wgray_next == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1],
                                      wq2_rptr[ADDR_SIZE-2:0]});
      half_full_val = (wocc >= HALF);
   end

   always_ff @(posedge wclk or negedge wrst) begin
      if (!wrst) begin
         wbin       <= '0;
         wptr       <= '0;
         wFull      <= 1'b0;
         wHalf_full <= 1'b0;
      end else begin
         wbin       <= wbin_next;
         wptr       <= wgray_next;
         wFull      <= full_val;
         wHalf_full <= half_full_val;
      end
   end

   // read pointer into the write domain
   always_ff @(posedge wclk or negedge wrst) begin
      if (!wrst) begin
         wq1_rptr <= '0;
         wq2_rptr <= '0;
      end else begin
         wq1_rptr <= rptr;
         wq2_rptr <= wq1_rptr;
      end
   end

   // ----------------------------------------------------------------- read side
   assign rData = mem[rbin[ADDR_SIZE-1:0]];

   always_comb begin
      rbin_next      = rbin + (ADDR_SIZE + 1)'(rinc && !rEmpty);
      rgray_next     = rbin_next ^ (rbin_next >> 1);
      rq2_wbin       = gray2bin(rq2_wptr);
      rocc           = rq2_wbin - rbin_next;
      empty_val      = (rgray_next == rq2_wptr);
      half_empty_val = (rocc <= HALF);
   end

   always_ff @(posedge rclk or negedge rrst) begin
      if (!rrst) begin
         rbin        <= '0;
         rptr        <= '0;
         rEmpty      <= 1'b1;
         rHalf_empty <= 1'b1;
      end else begin
         rbin        <= rbin_next;
         rptr        <= rgray_next;
         rEmpty      <= empty_val;
         rHalf_empty <= half_empty_val;
      end
   end

   // write pointer into the read domain
   always_ff @(posedge rclk or negedge rrst) begin
      if (!rrst) begin
         rq1_wptr <= '0;
         rq2_wptr <= '0;
      end else begin
         rq1_wptr <= wptr;
         rq2_wptr <= rq1_wptr;
      end
   end

endmodule

// File: tb/tb_async_fifo.sv
// -----------------------------------------------------------------------------
// tb_async_fifo
//   Directed bench for async_fifo. Two instances share wclk (20 ns) and
//   rclk (70 ns): a small one (DATA_SIZE=12, ADDR_SIZE=4) for reset, single
//   word, fill, drain and wrap checks, and a large one (12/12) for the
//   2050-word ordering run. Expected data comes from a write-order queue.
// -----------------------------------------------------------------------------
module tb_async_fifo;

   logic wclk = 1'b0;
   logic rclk = 1'b0;
   logic wrst, rrst;

   logic [11:0] s_wData, s_rData;
   logic        s_winc, s_rinc, s_wFull, s_wHalf_full, s_rEmpty, s_rHalf_empty;

   logic [11:0] l_wData, l_rData;
   logic        l_winc, l_rinc, l_wFull, l_wHalf_full, l_rEmpty, l_rHalf_empty;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [11:0] q[$];
   logic [11:0] exp_w;

   async_fifo #(.DATA_SIZE(12), .ADDR_SIZE(4)) dut_s (
      .wclk(wclk), .wrst(wrst), .rclk(rclk), .rrst(rrst),
      .wData(s_wData), .winc(s_winc), .rinc(s_rinc), .rData(s_rData),
      .wFull(s_wFull), .wHalf_full(s_wHalf_full),
      .rEmpty(s_rEmpty), .rHalf_empty(s_rHalf_empty)
   );

   async_fifo #(.DATA_SIZE(12), .ADDR_SIZE(12)) dut_l (
      .wclk(wclk), .wrst(wrst), .rclk(rclk), .rrst(rrst),
      .wData(l_wData), .winc(l_winc), .rinc(l_rinc), .rData(l_rData),
      .wFull(l_wFull), .wHalf_full(l_wHalf_full),
      .rEmpty(l_rEmpty), .rHalf_empty(l_rHalf_empty)
   );

   always #10 wclk = ~wclk;
   initial begin
      #3;
      forever #35 rclk = ~rclk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr_s(input logic [11:0] d);
      @(negedge wclk);
      s_wData = d;
      s_winc  = 1'b1;
      @(negedge wclk);
      s_winc  = 1'b0;
   endtask

   task automatic pop_s;
      @(negedge rclk);
      s_rinc = 1'b1;
      @(negedge rclk);
      s_rinc = 1'b0;
   endtask

   initial begin
      int unsigned k;
      int unsigned n;
      int unsigned m;
      wrst = 1'b0; rrst = 1'b0;
      s_wData = '0; s_winc = 1'b0; s_rinc = 1'b0;
      l_wData = '0; l_winc = 1'b0; l_rinc = 1'b0;

      // ---- reset
      repeat (3) @(negedge rclk);
      chk("rst_s_wFull",       32'(s_wFull),       32'd0);
      chk("rst_s_wHalf_full",  32'(s_wHalf_full),  32'd0);
      chk("rst_s_rEmpty",      32'(s_rEmpty),      32'd1);
      chk("rst_s_rHalf_empty", 32'(s_rHalf_empty), 32'd1);
      chk("rst_l_wFull",       32'(l_wFull),       32'd0);
      chk("rst_l_rEmpty",      32'(l_rEmpty),      32'd1);
      @(negedge wclk); wrst = 1'b1;
      @(negedge rclk); rrst = 1'b1;

      // rinc while empty must not move the read pointer
      repeat (3) pop_s();
      chk("empty_pop_rEmpty", 32'(s_rEmpty), 32'd1);

      // ---- single word and visibility latency
      wr_s(12'hA5C);
      k = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge rclk); #1;
         k++;
         if (!s_rEmpty) break;
      end
      chk("latency_le3", 32'(k <= 3), 32'd1);
      chk("single_rEmpty", 32'(s_rEmpty), 32'd0);
      chk("single_rData", 32'(s_rData), 32'hA5C);
      pop_s();
      chk("single_pop_rEmpty", 32'(s_rEmpty), 32'd1);

      // ---- fill 16 words with no reads; pointers sit at 1
      repeat (8) @(negedge wclk);
      for (int i = 1; i <= 16; i++) begin
         wr_s(12'(12'h100 + i));
         if (i == 7)  chk("fill7_wHalf_full",  32'(s_wHalf_full), 32'd0);
         if (i == 8)  chk("fill8_wHalf_full",  32'(s_wHalf_full), 32'd1);
         if (i == 15) chk("fill15_wFull",      32'(s_wFull),      32'd0);
         if (i == 16) chk("fill16_wFull",      32'(s_wFull),      32'd1);
      end
      wr_s(12'hBAD);
      chk("fill17_wFull", 32'(s_wFull), 32'd1);

      // ---- drain: half-empty after 8 pops, empty after 16
      repeat (5) @(negedge rclk);
      chk("full_rHalf_empty", 32'(s_rHalf_empty), 32'd0);
      chk("full_rEmpty",      32'(s_rEmpty),      32'd0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge rclk);
         exp_w = 12'(12'h100 + i);
         chk($sformatf("drain_data_%0d", i), 32'(s_rData), 32'(exp_w));
         s_rinc = 1'b1;
         @(negedge rclk);
         s_rinc = 1'b0;
         if (i == 7)  chk("drain7_rHalf_empty", 32'(s_rHalf_empty), 32'd0);
         if (i == 8)  chk("drain8_rHalf_empty", 32'(s_rHalf_empty), 32'd1);
         if (i == 15) chk("drain15_rEmpty",     32'(s_rEmpty),      32'd0);
         if (i == 16) chk("drain16_rEmpty",     32'(s_rEmpty),      32'd1);
      end
      pop_s();
      chk("extra_pop_rEmpty", 32'(s_rEmpty), 32'd1);
      // a moved read pointer would show a stale slot instead of this word
      wr_s(12'h3C3);
      for (int i = 0; i < 8; i++) begin
         @(negedge rclk);
         if (!s_rEmpty) break;
      end
      chk("after_extra_rEmpty", 32'(s_rEmpty), 32'd0);
      chk("after_extra_rData",  32'(s_rData),  32'h3C3);
      pop_s();
      repeat (6) @(negedge wclk);
      chk("idle_wHalf_full", 32'(s_wHalf_full), 32'd0);

      // ---- wrap: 100 words, writer every wclk, reader every rclk
      q.delete();
      n = 0; m = 0;
      fork
         begin
            for (int c = 0; c < 20000 && n < 100; c++) begin
               @(negedge wclk);
               if (!s_wFull) begin
                  chk("wrap_no_false_full", 32'(q.size() < 16), 32'd1);
                  s_wData = 12'($urandom_range(0, 4095));
                  s_winc  = 1'b1;
                  q.push_back(s_wData);
                  n++;
               end else begin
                  s_winc = 1'b0;
               end
            end
            @(negedge wclk);
            s_winc = 1'b0;
         end
         begin
            for (int c = 0; c < 20000 && m < 100; c++) begin
               @(negedge rclk);
               if (!s_rEmpty) begin
                  chk("wrap_no_false_empty", 32'(q.size() > 0), 32'd1);
                  if (q.size() > 0) begin
                     exp_w = q.pop_front();
                     chk("wrap_data", 32'(s_rData), 32'(exp_w));
                  end
                  s_rinc = 1'b1;
                  m++;
               end else begin
                  s_rinc = 1'b0;
               end
            end
            @(negedge rclk);
            s_rinc = 1'b0;
         end
      join
      chk("wrap_written", n, 32'd100);
      chk("wrap_read",    m, 32'd100);
      chk("wrap_end_rEmpty", 32'(s_rEmpty), 32'd1);

      // ---- ordering: 2050 words through the 4096-deep instance
      q.delete();
      n = 0; m = 0;
      fork
         begin
            for (int c = 0; c < 20000 && n < 2050; c++) begin
               @(negedge wclk);
               if (!l_wFull && !l_winc) begin
                  l_wData = 12'($urandom_range(0, 4095));
                  l_winc  = 1'b1;
                  q.push_back(l_wData);
                  n++;
               end else begin
                  l_winc = 1'b0;
               end
            end
            @(negedge wclk);
            l_winc = 1'b0;
         end
         begin
            for (int c = 0; c < 20000 && m < 2050; c++) begin
               @(negedge rclk);
               if (!l_rEmpty && !l_rinc) begin
                  if (q.size() > 0) begin
                     exp_w = q.pop_front();
                     chk("order_data", 32'(l_rData), 32'(exp_w));
                  end else begin
                     chk("order_false_empty", 32'd1, 32'd0);
                  end
                  l_rinc = 1'b1;
                  m++;
               end else begin
                  l_rinc = 1'b0;
               end
            end
            @(negedge rclk);
            l_rinc = 1'b0;
         end
      join
      chk("order_written", n, 32'd2050);
      chk("order_read",    m, 32'd2050);
      @(negedge rclk);
      chk("order_end_rEmpty", 32'(l_rEmpty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
